// File: rtl/inv_key_schedule.sv
// inv_key_schedule: iterative AES-128 inverse key scheduler.
// It is loaded with the round-10 key and steps the key recurrence backwards.
// Round keys 10..0 are emitted one per valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      load request, sampled only while idle
//   key_in     round-10 key, w0 in [127:96]
//   round_key  current round key, same word order as key_in
//   round_idx  round number of round_key (10 down to 0)
//   rk_valid   round_key/round_idx are valid
//   rk_ready   consumer accepts the current round key
//   busy       a schedule is in progress
//   done       one-cycle pulse after round 0 is accepted

// aes_sbox: forward AES S-box, a single combinational byte lookup.
// Ports: a = input byte, y = substituted byte.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   // Entry 0 sits in the most significant byte, so row text reads in table order.
   localparam logic [2047:0] TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // ~a equals 255-a, which locates entry a counted from the MSB end.
   assign y = TABLE[{~a, 3'b000} +: 8];
endmodule

module inv_key_schedule (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t       state, state_nxt;
   logic [127:0] cur;
   logic [3:0]   r;
   logic         done_q;
   logic         load, step, last;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  p0, p1, p2, p3;
   logic [31:0]  rot, sub;
   logic [7:0]   rcon;
   logic [127:0] prev_key;

   assign {w0, w1, w2, w3} = cur;

   // Undoing w[i] = w[i-4] ^ w[i-1]: the preceding key's last word is recovered
   // first, then it feeds the RotWord/SubWord term that recovers its first word.
   assign p3  = w3 ^ w2;
   assign p2  = w2 ^ w1;
   assign p1  = w1 ^ w0;
   assign rot = {p3[23:0], p3[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_sub
      aes_sbox u_sbox (
         .a (rot[8*b +: 8]),
         .y (sub[8*b +: 8])
      );
   end

   // The constant belongs to the round being left, so the K10->K9 step uses 36.
   always_comb begin
      rcon = '0;
      case (r)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = '0;
      endcase
   end

   assign p0       = w0 ^ sub ^ {rcon, 24'h0};
   assign prev_key = {p0, p1, p2, p3};

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (rk_ready) begin
               if (r == 4'd0) begin
                  last      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  step = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur    <= '0;
         r      <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= last;
         if (load) begin
            cur <= key_in;
            r   <= 4'd10;
         end else if (step) begin
            cur <= prev_key;
            r   <= r - 4'd1;
         end
      end
   end

   assign round_key = cur;
   assign round_idx = r;
   assign rk_valid  = (state == RUN);
   assign busy      = (state == RUN);
   assign done      = done_q;
endmodule

// File: tb/tb_inv_key_schedule.sv
// tb_inv_key_schedule: self-checking bench for inv_key_schedule.
// The reference builds the S-box from GF(2^8) inversion plus the affine map.
// It runs the forward AES-128 key expansion and expects it back in reverse.
module tb_inv_key_schedule;
   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] key_in;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         rk_valid;
   logic         rk_ready;
   logic         busy;
   logic         done;

   int           n_cmp  = 0;
   int           n_fail = 0;
   logic [7:0]   ref_sbox [0:255];
   logic [127:0] got [0:10];

   inv_key_schedule dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key_in    (key_in),
      .round_key (round_key),
      .round_idx (round_idx),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox_math(input logic [7:0] x);
      logic [7:0] inv = 8'h00;
      if (x != 8'h00)
         for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   // Forward expansion of k0 up to round n, returning that round's key.
   function automatic logic [127:0] fwd_round_key(input logic [127:0] k0, input int n);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
            t = t ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one schedule for original key k0 and checks every emitted round key.
   // bp: random rk_ready with a 5-cycle stall at idx 7; poke: start with another
   // key at idx 4; chain: hold start through done to load next_k10.
   task automatic run_seq(input logic [127:0] k0, input bit skip_load, input bit bp,
                          input bit poke, input bit chain, input logic [127:0] next_k10);
      int exp_idx = 10;
      int stall   = 0;
      int cycles  = 0;
      bit poked   = 0;
      if (!skip_load) begin
         @(negedge clk);
         key_in   = fwd_round_key(k0, 10);
         start    = 1'b1;
         rk_ready = 1'b0;
      end
      while (exp_idx >= 0 && cycles < 200) begin
         @(negedge clk);
         cycles++;
         start = 1'b0;
         check("valid", 128'(rk_valid), 128'(1'b1));
         check("busy", 128'(busy), 128'(1'b1));
         check("done_low", 128'(done), 128'(1'b0));
         check("round_idx", 128'(round_idx), 128'(exp_idx));
         check("round_key", round_key, fwd_round_key(k0, exp_idx));
         got[exp_idx] = round_key;
         if (bp) begin
            if (exp_idx == 7 && stall < 5) begin
               rk_ready = 1'b0;
               stall++;
            end else begin
               rk_ready = 1'($urandom_range(0, 1));
            end
         end else begin
            rk_ready = 1'b1;
         end
         if (poke && exp_idx == 4 && !poked) begin
            start  = 1'b1;
            key_in = key_in ^ {$urandom, $urandom, $urandom, $urandom};
            poked  = 1;
         end
         if (chain && exp_idx == 0 && rk_ready) begin
            start  = 1'b1;
            key_in = next_k10;
         end
         if (rk_ready) exp_idx--;
      end
      if (exp_idx >= 0) check("schedule_timeout", 128'(exp_idx), 128'(-1));
      @(negedge clk);
      rk_ready = 1'b1;
      check("done_pulse", 128'(done), 128'(1'b1));
      check("valid_after", 128'(rk_valid), 128'(1'b0));
      check("busy_after", 128'(busy), 128'(1'b0));
      if (!chain) begin
         @(negedge clk);
         check("done_once", 128'(done), 128'(1'b0));
      end
   endtask

   initial begin
      logic [127:0] fips_key;
      logic [127:0] k;
      logic [127:0] kb;
      int           cnt;

      for (int i = 0; i < 256; i++) ref_sbox[i] = sbox_math(8'(i));

      rst_n    = 1'b0;
      start    = 1'b0;
      rk_ready = 1'b0;
      key_in   = '0;
      repeat (2) @(negedge clk);
      check("rst_round_key", round_key, 128'h0);
      check("rst_round_idx", 128'(round_idx), 128'h0);
      check("rst_valid", 128'(rk_valid), 128'h0);
      check("rst_busy", 128'(busy), 128'h0);
      check("rst_done", 128'(done), 128'h0);
      rst_n = 1'b1;

      // Idle: ready high and key_in changing without start
      rk_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         key_in = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         check("idle_valid", 128'(rk_valid), 128'h0);
         check("idle_busy", 128'(busy), 128'h0);
         check("idle_done", 128'(done), 128'h0);
      end

      // FIPS-197 example key
      fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      run_seq(fips_key, 0, 0, 0, 0, '0);
      check("fips_idx10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check("fips_idx9", got[9], 128'hac7766f319fadc2128d12941575c006e);
      check("fips_idx1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
      check("fips_idx0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

      // Cross-check with forward expansion
      k = 128'h98677fafd6adb70c59e8d947c971150f;
      run_seq(k, 0, 0, 0, 0, '0);
      check("xchk_idx0", got[0], 128'h98677fafd6adb70c59e8d947c971150f);
      for (int i = 0; i < 3; i++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         run_seq(k, 0, 0, 0, 0, '0);
      end

      // Backpressure
      for (int i = 0; i < 2; i++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         run_seq(k, 0, 1, 0, 0, '0);
      end

      // Start while busy, then start held through done
      k  = {$urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom};
      run_seq(k, 0, 0, 1, 1, fwd_round_key(kb, 10));
      run_seq(kb, 1, 0, 0, 0, '0);

      // Reset mid-schedule, between clock edges
      k = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      key_in   = fwd_round_key(k, 10);
      start    = 1'b1;
      rk_ready = 1'b1;
      cnt      = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         cnt++;
      end while (!(rk_valid && round_idx == 4'd5) && cnt < 30);
      check("reach_idx5", 128'(round_idx), 128'd5);
      rk_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_round_key", round_key, 128'h0);
      check("arst_round_idx", 128'(round_idx), 128'h0);
      check("arst_valid", 128'(rk_valid), 128'h0);
      check("arst_busy", 128'(busy), 128'h0);
      check("arst_done", 128'(done), 128'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("arst_hold_done", 128'(done), 128'h0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_done", 128'(done), 128'h0);
         check("post_rst_valid", 128'(rk_valid), 128'h0);
      end
      run_seq(k, 0, 0, 0, 0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
